// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG DCT datapath: block geometry, sample type,
// the feeder FSM states and a helper that extracts one lane from a packed row.
package jpeg_pkg;

  localparam int N_DCT    = 8;
  localparam int SAMPLE_W = 8;

  typedef logic signed [SAMPLE_W-1:0] lane_sample_t;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_GAP = 1'b1
  } feeder_state_t;

  // Lane k of a packed block row lives at bits [k*SAMPLE_W +: SAMPLE_W].
  function automatic lane_sample_t lane_slice(input logic [N_DCT*SAMPLE_W-1:0] row,
                                              input int unsigned k);
    return lane_sample_t'(row >> (k * SAMPLE_W));
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-length register chain used to give each PE row-lane its diagonal skew.
// DEPTH=0 degenerates to a plain wire.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = ^{clk_i, rst_n_i};
      assign q_o = d_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift the lane word one stage further down the chain every cycle.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_skew_feeder.sv
// Feeds 8x8 sample blocks into the PE array's y-inputs. Rows arrive over a
// valid/ready handshake; lane k leaves k cycles after lane 0 and every empty
// slot is a zero bubble because the PEs accumulate every cycle.
module systolic_skew_feeder
  import jpeg_pkg::*;
#(
  parameter int N       = N_DCT,
  parameter int Y_WIDTH = SAMPLE_W,
  parameter int GAP     = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [N*Y_WIDTH-1:0] in_data_i,
  output logic [N*Y_WIDTH-1:0] out_y_o,
  output logic [N-1:0]         out_vld_o,
  output logic [N-1:0]         out_last_o,
  output logic                 blk_done_o
);

  localparam int              ROW_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N - 1);
  localparam logic [7:0]      GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  feeder_state_t        state_q;
  logic [ROW_W-1:0]     row_cnt_q;
  logic [7:0]           gap_cnt_q;
  logic                 accept;
  logic                 last_row;

  logic [N*Y_WIDTH-1:0] s0_data_q;
  logic [N-1:0]         s0_vld_q;
  logic [N-1:0]         s0_last_q;

  assign accept   = in_valid_i && in_ready_o;
  assign last_row = (row_cnt_q == ROW_LAST);

  // Row/gap sequencing; in_ready_o is registered so it never depends on in_valid_i.
  // Reset clears every output, so ready first rises on the cycle after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RUN;
      in_ready_o <= 1'b0;
      row_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          in_ready_o <= 1'b1;
          if (accept) begin
            if (last_row) begin
              row_cnt_q <= '0;
              if (GAP > 0) begin
                state_q    <= ST_GAP;
                in_ready_o <= 1'b0;
                gap_cnt_q  <= '0;
              end
            end else begin
              row_cnt_q <= row_cnt_q + ROW_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q    <= ST_RUN;
            in_ready_o <= 1'b1;
            gap_cnt_q  <= '0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          in_ready_o <= 1'b0;
        end
      endcase
    end
  end

  // Stage 0 captures an accepted row, otherwise a zero bubble with no valid/last.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s0_data_q <= '0;
      s0_vld_q  <= '0;
      s0_last_q <= '0;
    end else if (accept) begin
      s0_data_q <= in_data_i;
      s0_vld_q  <= '1;
      s0_last_q <= {N{last_row}};
    end else begin
      s0_data_q <= '0;
      s0_vld_q  <= '0;
      s0_last_q <= '0;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [Y_WIDTH+1:0] lane_q;

    skew_delay_line #(
      .DEPTH(k),
      .WIDTH(Y_WIDTH + 2)
    ) u_delay (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .d_i    ({s0_last_q[k], s0_vld_q[k], s0_data_q[k*Y_WIDTH +: Y_WIDTH]}),
      .q_o    (lane_q)
    );

    assign out_y_o[k*Y_WIDTH +: Y_WIDTH] = lane_q[Y_WIDTH-1:0];
    assign out_vld_o[k]                  = lane_q[Y_WIDTH];
    assign out_last_o[k]                 = lane_q[Y_WIDTH+1];
  end

  assign blk_done_o = out_last_o[N-1] & out_vld_o[N-1];

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: one instance with GAP=7 and one
// with GAP=0. A reference model pushes the expected per-lane slot at every
// clock edge; a monitor pops and compares every lane on every falling edge.
module tb_systolic_skew_feeder;
  import jpeg_pkg::*;

  localparam int N  = N_DCT;
  localparam int YW = SAMPLE_W;
  localparam int RW = N * YW;

  typedef struct packed {
    lane_sample_t d;
    logic         v;
    logic         l;
  } slot_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          inVld   [2];
  logic [RW-1:0] inData  [2];
  logic          inReady [2];
  logic [RW-1:0] outY    [2];
  logic [N-1:0]  outVld  [2];
  logic [N-1:0]  outLast [2];
  logic          outDone [2];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic  expReady [2];
  logic  lastAcc  [2];
  logic  inGap    [2];
  int    rowCnt   [2];
  int    gapCnt   [2];
  slot_t laneQ    [2*N][$];
  int    acceptEdges [2][$];
  int    doneEdges   [2][$];
  int    readyLow    [2][$];

  systolic_skew_feeder #(.N(N), .Y_WIDTH(YW), .GAP(7)) dut_gap7 (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(inVld[0]), .in_ready_o(inReady[0]), .in_data_i(inData[0]),
    .out_y_o(outY[0]), .out_vld_o(outVld[0]), .out_last_o(outLast[0]),
    .blk_done_o(outDone[0])
  );

  systolic_skew_feeder #(.N(N), .Y_WIDTH(YW), .GAP(0)) dut_gap0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(inVld[1]), .in_ready_o(inReady[1]), .in_data_i(inData[1]),
    .out_y_o(outY[1]), .out_vld_o(outVld[1]), .out_last_o(outLast[1]),
    .blk_done_o(outDone[1])
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic int gapOf(input int i);
    return (i == 0) ? 7 : 0;
  endfunction

  function automatic logic [RW-1:0] mkRow(input int base);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r = r | (RW'(YW'(base + k)) << (k * YW));
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference model: at each edge decide acceptance from the modelled ready,
  // push the slot each lane should show (lane k pre-loaded with k zeros for its skew).
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        expReady[i] = 1'b0;
        lastAcc[i]  = 1'b0;
        inGap[i]    = 1'b0;
        rowCnt[i]   = 0;
        gapCnt[i]   = 0;
        for (int k = 0; k < N; k++) begin
          laneQ[i*N+k].delete();
          for (int z = 0; z < k; z++) laneQ[i*N+k].push_back('0);
        end
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        logic  acc;
        logic  tag;
        slot_t s;
        acc = inVld[i] && expReady[i];
        tag = acc && (rowCnt[i] == N - 1);
        lastAcc[i] = acc;
        if (acc) acceptEdges[i].push_back(cyc);
        for (int k = 0; k < N; k++) begin
          s.d = acc ? lane_slice(inData[i], k) : '0;
          s.v = acc;
          s.l = tag;
          laneQ[i*N+k].push_back(s);
        end
        if (inGap[i]) begin
          if (gapCnt[i] == gapOf(i) - 1) begin
            inGap[i]    = 1'b0;
            gapCnt[i]   = 0;
            expReady[i] = 1'b1;
          end else begin
            gapCnt[i]++;
          end
        end else begin
          expReady[i] = 1'b1;
          if (acc) begin
            if (rowCnt[i] == N - 1) begin
              rowCnt[i] = 0;
              if (gapOf(i) > 0) begin
                inGap[i]    = 1'b1;
                gapCnt[i]   = 0;
                expReady[i] = 1'b0;
              end
            end else begin
              rowCnt[i]++;
            end
          end
        end
      end
    end
  end

  // Monitor: every falling edge out of reset, pop one slot per lane and compare.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        logic [RW-1:0] ey;
        logic [N-1:0]  ev;
        logic [N-1:0]  el;
        slot_t         s;
        ey = '0;
        ev = '0;
        el = '0;
        for (int k = 0; k < N; k++) begin
          if (laneQ[i*N+k].size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL inst%0d lane%0d scoreboard: got empty queue, required a slot", i, k);
          end else begin
            s  = laneQ[i*N+k].pop_front();
            ey = ey | (RW'($unsigned(s.d)) << (k * YW));
            ev[k] = s.v;
            el[k] = s.l;
          end
        end
        checkOutput($sformatf("inst%0d out_y", i),      64'(outY[i]),    64'(ey));
        checkOutput($sformatf("inst%0d out_vld", i),    64'(outVld[i]),  64'(ev));
        checkOutput($sformatf("inst%0d out_last", i),   64'(outLast[i]), 64'(el));
        checkOutput($sformatf("inst%0d blk_done", i),   64'(outDone[i]), 64'(el[N-1] & ev[N-1]));
        checkOutput($sformatf("inst%0d in_ready", i),   64'(inReady[i]), 64'(expReady[i]));
        if (outDone[i]) doneEdges[i].push_back(cyc);
        if (!inReady[i]) readyLow[i].push_back(cyc);
      end
    end
  end

  // Offer one row and hold it until accepted (bounded wait).
  task automatic applyStimulus(input int i, input logic [RW-1:0] d);
    int guard;
    guard = 0;
    inVld[i]  = 1'b1;
    inData[i] = d;
    @(negedge clk);
    while (!lastAcc[i] && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    total++;
    if (!lastAcc[i]) begin
      bad++;
      $display("[TB] FAIL inst%0d accept timeout: got no accept, required one within 300 cycles", i);
    end
    inVld[i]  = 1'b0;
    inData[i] = '0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearLogs(input int i);
    acceptEdges[i].delete();
    doneEdges[i].delete();
    readyLow[i].delete();
  endtask

  task automatic checkReset(input int i);
    checkOutput($sformatf("inst%0d reset out_y", i),    64'(outY[i]),    64'd0);
    checkOutput($sformatf("inst%0d reset out_vld", i),  64'(outVld[i]),  64'd0);
    checkOutput($sformatf("inst%0d reset out_last", i), 64'(outLast[i]), 64'd0);
    checkOutput($sformatf("inst%0d reset blk_done", i), 64'(outDone[i]), 64'd0);
    checkOutput($sformatf("inst%0d reset in_ready", i), 64'(inReady[i]), 64'd0);
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 100000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ae0;
    for (int i = 0; i < 2; i++) begin
      inVld[i]  = 1'b0;
      inData[i] = '0;
    end

    // Power-on reset
    #1 rst_n = 1'b0;
    #2;
    checkReset(0);
    checkReset(1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Idle input
    idleCycles(20);
    checkOutput("idle in_ready", 64'(inReady[0]), 64'd1);
    checkOutput("idle out_vld",  64'(outVld[0]),  64'd0);

    // Single block, row r lane k = 8r+k
    clearLogs(0);
    for (int r = 0; r < N; r++) applyStimulus(0, mkRow(8 * r));
    idleCycles(16);
    checkOutput("single accepts", 64'(acceptEdges[0].size()), 64'd8);
    checkOutput("single done count", 64'(doneEdges[0].size()), 64'd1);
    if (doneEdges[0].size() > 0 && acceptEdges[0].size() > 0)
      checkOutput("single done cycle", 64'(doneEdges[0][0] - acceptEdges[0][0] + 1), 64'd15);

    // Gap enforcement across two blocks with valid held high
    clearLogs(0);
    for (int r = 0; r < 2 * N; r++) applyStimulus(0, mkRow(64 + 8 * r));
    idleCycles(16);
    checkOutput("gap accepts", 64'(acceptEdges[0].size()), 64'd16);
    if (acceptEdges[0].size() >= 9) begin
      ae0 = acceptEdges[0][0];
      checkOutput("gap row7 cycle",   64'(acceptEdges[0][7] - ae0), 64'd7);
      checkOutput("gap blk2 cycle",   64'(acceptEdges[0][8] - ae0), 64'd15);
      checkOutput("gap low count",    64'(readyLow[0].size()),      64'd14);
      if (readyLow[0].size() >= 8) begin
        checkOutput("gap low first",  64'(readyLow[0][0] - ae0 + 1), 64'd8);
        checkOutput("gap low last",   64'(readyLow[0][6] - ae0 + 1), 64'd14);
        checkOutput("gap2 low first", 64'(readyLow[0][7] - ae0 + 1), 64'd23);
      end
    end

    // Sparse input: valid toggles 1,0,1,0
    clearLogs(0);
    for (int r = 0; r < N; r++) begin
      applyStimulus(0, mkRow(100 + 8 * r));
      idleCycles(1);
    end
    idleCycles(16);
    checkOutput("sparse done count", 64'(doneEdges[0].size()), 64'd1);
    if (acceptEdges[0].size() == 8) begin
      checkOutput("sparse spacing", 64'(acceptEdges[0][7] - acceptEdges[0][0]), 64'd14);
      if (doneEdges[0].size() > 0)
        checkOutput("sparse done cycle", 64'(doneEdges[0][0] - acceptEdges[0][0] + 1), 64'd22);
    end

    // GAP=0 back-to-back: three blocks streamed contiguously
    clearLogs(1);
    for (int r = 0; r < 3 * N; r++) applyStimulus(1, mkRow(8 * r));
    idleCycles(12);
    checkOutput("b2b accepts", 64'(acceptEdges[1].size()), 64'd24);
    checkOutput("b2b done count", 64'(doneEdges[1].size()), 64'd3);
    checkOutput("b2b ready low", 64'(readyLow[1].size()), 64'd0);
    if (acceptEdges[1].size() == 24 && doneEdges[1].size() == 3) begin
      ae0 = acceptEdges[1][0];
      checkOutput("b2b contiguous", 64'(acceptEdges[1][23] - ae0), 64'd23);
      for (int j = 0; j < 3; j++)
        checkOutput($sformatf("b2b done%0d cycle", j), 64'(doneEdges[1][j] - ae0 + 1), 64'(15 + 8 * j));
    end

    // Reset in the middle of a block
    clearLogs(0);
    for (int r = 0; r < 5; r++) applyStimulus(0, mkRow(200 + r));
    checkOutput("pre-reset out_vld", 64'(outVld[0][0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkReset(0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    clearLogs(0);
    for (int r = 0; r < N; r++) applyStimulus(0, mkRow(8 * r + 3));
    idleCycles(16);
    checkOutput("post-reset done count", 64'(doneEdges[0].size()), 64'd1);
    if (doneEdges[0].size() > 0 && acceptEdges[0].size() > 0)
      checkOutput("post-reset done cycle", 64'(doneEdges[0][0] - acceptEdges[0][0] + 1), 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Transmit side of the PE systolic array's y-input interface. Accepts 8x8 sample blocks row by row over a valid/ready handshake.
- Drives the N row-lanes (out_y_o) of the array with the diagonal time skew it requires: lane k is delayed k cycles relative to lane 0.
- Inserts zero bubbles wherever no sample is present, because every PE accumulates unconditionally each cycle.
- Sits between the level-shift/sample buffer and the DCT PE array.

Parameters:
- N, 8, array dimension: lanes per row and rows per block.
- Y_WIDTH, 8, signed sample width per lane; must match the PE's Y_WIDTH.
- GAP, 7, zero-bubble cycles forced between blocks, with in_ready_o low. Legal range 0..255.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- in_valid_i  in  1  row beat valid.
- in_ready_o  out  1  feeder can accept a row this cycle.
- in_data_i  in  N*Y_WIDTH  one block row; lane k = bits [k*Y_WIDTH +: Y_WIDTH].
- out_y_o  out  N*Y_WIDTH  skewed lane samples to the PE array, same lane packing.
- out_vld_o  out  N  per-lane sample-valid, skewed identically to the data.
- out_last_o  out  N  per-lane flag marking row N-1 of a block, skewed identically.
- blk_done_o  out  1  one-cycle pulse when lane N-1 emits the last row of a block.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, every delay stage 0, FSM to RUN, row_cnt=0, gap_cnt=0. Reset mid-block discards partial block and all in-flight stages. No recovery sequence; next accepted row is row 0.
- Handshake: row accepted when in_valid_i && in_ready_o. in_ready_o is a registered FSM output, independent of in_valid_i in the same cycle. No output backpressure: array consumes every cycle.
- FSM states:
  - RUN: in_ready_o=1. Each accept increments row_cnt. Accept with row_cnt==N-1 sets row_cnt=0, tags the beat last, then goes to GAP (or stays in RUN if GAP==0).
  - GAP: in_ready_o=0, gap_cnt counts 0..GAP-1, then returns to RUN. Lane 0 sees zero bubbles throughout.
- Stage-0 register, every cycle:
  - With accept: captures in_data_i, vld=all 1, last=tag.
  - Without accept (idle or GAP): captures data=0, vld=0, last=0.
- Lane k path: stage-0 slice k followed by k further registers.
  - Latency of lane k = 1+k cycles from accept edge.
  - Lane 0 latency = 1; lane N-1 latency = N.
  - Total register bits = N(N+1)/2 * (Y_WIDTH+2).
- Invalid slots always carry zero data (never stale); verify out_y_o == 0 wherever out_vld_o[k]==0.
- blk_done_o = out_last_o[N-1] && out_vld_o[N-1].
- Back-to-back blocks with GAP=0: rows of consecutive blocks are contiguous; skew still holds per lane; no sample lost or duplicated.
- in_valid_i held high during GAP: nothing accepted; in_data_i ignored. Source must hold its data (standard valid/ready).
- Row counter wrap: exactly N accepts per block; no explicit last input.

Decomposition:
- Shared package jpeg_pkg: N_DCT=8, SAMPLE_W=8, lane slice helper function, typedef lane_sample_t (logic signed [SAMPLE_W-1:0]).
- One sub-module: skew_delay_line (parameters DEPTH, WIDTH; DEPTH=0 pass-through), instantiated per lane via generate.
- FSM and counters live in the top module.

Test Plan:
- Single block: 8 rows, row r lane k = 8r+k, valid held high -> lane k emits 8r+k at cycle 1+k+r after first accept; blk_done_o pulses at cycle 15.
- Idle input (in_valid_i=0 for 20 cycles after reset) -> out_y_o all 0, out_vld_o=0, in_ready_o=1.
- Gap enforcement (GAP=7, valid held high across 2 blocks) -> in_ready_o low exactly cycles 8..14; block 2 row 0 accepted at cycle 15; all lanes zero between blocks.
- Sparse input: in_valid_i toggled 1,0,1,0 -> each lane shows sample/zero alternation with out_vld_o matching, values intact, skew preserved.
- GAP=0 back-to-back: 3 blocks streamed continuously -> 24 contiguous valid beats per lane, out_last_o[k] at rows 7, 15, 23 (+k), 3 blk_done_o pulses.
- Reset asserted at row 4 of block 1 -> outputs 0 immediately (async); after release, next block row 0 emitted cleanly, no residual valid.
